cpu_bcd_store: RTL and testbench

CPU_BCD_STORE -- requirements
Module: cpu_bcd_store

---
 rtl/cpu_bcd_store.sv | 134 +++++++++++++
 tb/tb_cpu_bcd_store.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bcd_store.sv
// CHIP-8 FX33 executor: converts Vx to three BCD digits and writes them to
// memory at I, I+1, I+2 through a ready/valid-style write port.

module cpu_bcd (
    input  logic [7:0] bin,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [19:0] sh;

    // Double-dabble: add 3 to any digit >= 5 before each left shift.
    always_comb begin
        // NOTE: every always_comb variable gets a default first so no latch is inferred.
        sh = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
            if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
            if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
            sh = sh << 1;
        end
        hundreds = sh[19:16];
        tens     = sh[15:12];
        ones     = sh[11:8];
    end

endmodule

module cpu_bcd_store #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        vx,
    input  logic [ADDR_W-1:0] i_reg,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        WR_H,
        WR_T,
        WR_O,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        bcd_h;
    logic [3:0]        bcd_t;
    logic [3:0]        bcd_o;
    logic [3:0]        h_q;
    logic [3:0]        t_q;
    logic [3:0]        o_q;
    logic [ADDR_W-1:0] addr_q;

    cpu_bcd u_bcd (
        .bin      (vx),
        .hundreds (bcd_h),
        .tens     (bcd_t),
        .ones     (bcd_o)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Operands are captured only on acceptance so later vx/i_reg changes cannot leak in.
    always_ff @(posedge clk) begin
        // NOTE: these are plain registers, not a memory, so clearing them on reset is cheap and required.
        if (!reset_n) begin
            h_q    <= '0;
            t_q    <= '0;
            o_q    <= '0;
            addr_q <= '0;
        end else if (state == IDLE && start) begin
            h_q    <= bcd_h;
            t_q    <= bcd_t;
            o_q    <= bcd_o;
            addr_q <= i_reg;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = WR_H;
            WR_H:    if (mem_ready) state_nxt = WR_T;
            WR_T:    if (mem_ready) state_nxt = WR_O;
            WR_O:    if (mem_ready) state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Outputs depend only on state and captured registers, never on inputs directly.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: busy = 1'b0;
            WR_H: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = {4'd0, h_q};
            end
            WR_T: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q + ADDR_W'(1);
                mem_wdata = {4'd0, t_q};
            end
            WR_O: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q + ADDR_W'(2);
                mem_wdata = {4'd0, o_q};
            end
            DONE:    done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cpu_bcd_store.sv
// Directed self-checking bench for cpu_bcd_store: logs accepted writes and
// done/busy cycles at the falling edge and compares against hand-computed values.

module tb_cpu_bcd_store;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [7:0]        vx;
    logic [ADDR_W-1:0] i_reg;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_ready;
    logic              busy;
    logic              done;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int done_cyc = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [7:0]        wr_data[$];
    int                wr_cyc[$];

    cpu_bcd_store #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .vx        (vx),
        .i_reg     (i_reg),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after rising edges, so the falling edge sees what the next edge accepts.
    always @(negedge clk) begin
        if (mem_we && mem_ready) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    // Returns one cycle after acceptance (DUT in WR_H); operands are scrambled afterwards.
    task automatic issue(input logic [7:0] v, input logic [ADDR_W-1:0] base);
        @(posedge clk); #1;
        start = 1'b1;
        vx    = v;
        i_reg = base;
        @(posedge clk); #1;
        start = 1'b0;
        vx    = 8'($urandom);
        i_reg = ADDR_W'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic check_op(input string tag, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                            input logic [ADDR_W-1:0] a2, input logic [7:0] h, input logic [7:0] t,
                            input logic [7:0] o);
        check({tag, "_nwr"}, wr_addr.size(), 3);
        check({tag, "_ndone"}, done_cnt, 1);
        if (wr_addr.size() == 3) begin
            check({tag, "_a0"}, wr_addr[0], a0);
            check({tag, "_d0"}, wr_data[0], h);
            check({tag, "_a1"}, wr_addr[1], a1);
            check({tag, "_d1"}, wr_data[1], t);
            check({tag, "_a2"}, wr_addr[2], a2);
            check({tag, "_d2"}, wr_data[2], o);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_we"}, mem_we, 1'b0);
        check({tag, "_addr"}, mem_addr, '0);
        check({tag, "_wdata"}, mem_wdata, '0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b1;
        mem_ready = 1'b1;
        vx        = 8'h55;
        i_reg     = 12'h123;

        // Reset overrides a simultaneous start.
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        start   = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("post_reset");

        // 255 at 0x300: consecutive writes, one done right after, busy for 4 cycles.
        clear_log();
        issue(8'hFF, 12'h300);
        check("ff_wr_h_addr", mem_addr, 12'h300);
        wait_idle("ff");
        check_op("ff", 12'h300, 12'h301, 12'h302, 8'd2, 8'd5, 8'd5);
        check("ff_busy_cycles", busy_cnt, 4);
        if (wr_cyc.size() == 3) begin
            check("ff_consec1", wr_cyc[1] - wr_cyc[0], 1);
            check("ff_consec2", wr_cyc[2] - wr_cyc[1], 1);
            check("ff_done_lat", done_cyc - wr_cyc[2], 1);
        end
        check_outputs_zero("ff_idle");

        clear_log();
        issue(8'h00, 12'h200);
        wait_idle("zero");
        check_op("zero", 12'h200, 12'h201, 12'h202, 8'd0, 8'd0, 8'd0);

        clear_log();
        issue(8'h07, 12'h200);
        wait_idle("seven");
        check_op("seven", 12'h200, 12'h201, 12'h202, 8'd0, 8'd0, 8'd7);

        // Address wraps modulo 4 KiB.
        clear_log();
        issue(8'd123, 12'hFFE);
        wait_idle("wrap");
        check_op("wrap", 12'hFFE, 12'hFFF, 12'h000, 8'd1, 8'd2, 8'd3);

        // 154 at 0x123 with a 5-cycle stall in WR_T.
        clear_log();
        issue(8'd154, 12'h123);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_we", mem_we, 1'b1);
            check("stall_addr", mem_addr, 12'h124);
            check("stall_wdata", mem_wdata, 8'd5);
            @(posedge clk); #1;
        end
        check("stall_hold_addr", mem_addr, 12'h124);
        mem_ready = 1'b1;
        wait_idle("stall");
        check_op("stall", 12'h123, 12'h124, 12'h125, 8'd1, 8'd5, 8'd4);

        // Second start in WR_H with different operands is ignored.
        clear_log();
        issue(8'd45, 12'h050);
        start = 1'b1;
        vx    = 8'd255;
        i_reg = 12'h777;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("restart");
        check_op("restart", 12'h050, 12'h051, 12'h052, 8'd0, 8'd4, 8'd5);

        // Start held through DONE: ignored there, accepted on the IDLE edge right after.
        clear_log();
        issue(8'd99, 12'h600);
        wait_done("b2b");
        start = 1'b1;
        vx    = 8'd210;
        i_reg = 12'h700;
        @(posedge clk); #1;
        check("b2b_idle_gap", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", busy, 1'b1);
        check("b2b_addr", mem_addr, 12'h700);
        check("b2b_wdata", mem_wdata, 8'd2);
        wait_idle("b2b");
        check("b2b_nwr", wr_addr.size(), 6);
        check("b2b_ndone", done_cnt, 2);
        if (wr_data.size() == 6) begin
            check("b2b_first_ones", wr_data[2], 8'd9);
            check("b2b_second_ones", wr_data[5], 8'd0);
            check("b2b_second_a2", wr_addr[5], 12'h702);
        end

        // Reset for one edge while in WR_T aborts the write sequence.
        clear_log();
        issue(8'd200, 12'h400);
        @(posedge clk); #1;
        check("rst_in_wrt_addr", mem_addr, 12'h401);
        mem_ready = 1'b0;
        reset_n   = 1'b0;
        @(posedge clk); #1;
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        check_outputs_zero("rst_mid");
        repeat (4) @(posedge clk);
        #1;
        begin
            logic found = 1'b0;
            foreach (wr_addr[k]) if (wr_addr[k] == 12'h402) found = 1'b1;
            check("rst_no_wro", found, 1'b0);
        end
        check("rst_nwr", wr_addr.size(), 1);
        check("rst_ndone", done_cnt, 0);
        check_outputs_zero("rst_after");

        // Exhaustive digit sweep.
        for (int v = 0; v < 256; v++) begin
            clear_log();
            issue(8'(v), 12'h100);
            wait_idle("sweep");
            check("sweep_nwr", wr_data.size(), 3);
            if (wr_data.size() == 3) begin
                check("sweep_value", 100 * wr_data[0] + 10 * wr_data[1] + wr_data[2], v);
                check("sweep_h_range", wr_data[0] <= 8'd2, 1'b1);
                check("sweep_t_range", wr_data[1] <= 8'd9, 1'b1);
                check("sweep_o_range", wr_data[2] <= 8'd9, 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
